load_store_unit: RTL

- Sits between the CPU MEM stage and the SDRAM controller's data port.
- Turns a RISC-V load/store request (funct3, byte address, store data) into word-aligned memory accesses with byte enables.
- Extracts and sign- or zero-extends load data.
- Flags unsupported accesses, and either faults or splits misaligned accesses depending on build.

---
 rtl/load_store_unit.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Converts RISC-V load/store requests into word-aligned memory
//                accesses with byte enables, and sign/zero-extends load data.
//                Illegal funct3 values fault. Misaligned accesses fault unless
//                LSU_MISALIGN_SPLIT_EN is defined, in which case they are
//                performed as two aligned word accesses.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int ADDR_W = 25
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              req_rw,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_fault,
    output logic              mem_enable,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_valid,
    input  logic [31:0]       mem_rdata
);

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_ACC1 = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              rw_q, rw_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              fault_q, fault_d;
    logic              gap_q, gap_d;      // forces one idle cycle before the second access
    logic [31:0]       raw_lo_q, raw_lo_d; // needed lanes of the first word
    logic [31:0]       raw_hi_q, raw_hi_d; // needed lanes of the second word

    // Expand a 4-bit byte enable into a 32-bit byte-lane mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // Decode of the incoming request: legality and misalignment.
    logic [2:0] req_size;
    logic       req_legal;
    logic       req_misaligned;
    always_comb begin
        req_size = 3'd4;
        case (req_funct3[1:0])
            2'b00:   req_size = 3'd1;
            2'b01:   req_size = 3'd2;
            default: req_size = 3'd4;
        endcase
        req_legal = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: req_legal = 1'b1;
            3'b100, 3'b101:         req_legal = ~req_rw;
            default:                req_legal = 1'b0;
        endcase
        req_misaligned = ({1'b0, req_addr[1:0]} + req_size) > 3'd4;
    end

    // Lane geometry of the latched access: an 8-lane window spanning two words.
    logic [3:0]        size_mask;
    logic [7:0]        be_wide;
    logic [63:0]       wdata_wide;
    logic [31:0]       rd_word;
    logic [31:0]       rd_ext;
    logic [ADDR_W-1:0] word0_addr;
    logic [ADDR_W-1:0] word1_addr;
    always_comb begin
        size_mask = 4'b1111;
        case (funct3_q[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
        be_wide    = {4'b0000, size_mask} << addr_q[1:0];
        wdata_wide = {32'd0, wdata_q} << {addr_q[1:0], 3'b000};
        rd_word    = 32'({raw_hi_q, raw_lo_q} >> {addr_q[1:0], 3'b000});
        word0_addr = {addr_q[ADDR_W-1:2], 2'b00};
        word1_addr = word0_addr + ADDR_W'(4);
        rd_ext     = rd_word;
        case (funct3_q)
            3'b000:  rd_ext = {{24{rd_word[7]}}, rd_word[7:0]};
            3'b001:  rd_ext = {{16{rd_word[15]}}, rd_word[15:0]};
            3'b100:  rd_ext = {24'd0, rd_word[7:0]};
            3'b101:  rd_ext = {16'd0, rd_word[15:0]};
            default: rd_ext = rd_word;
        endcase
    end

    // Next-state and output logic of the access sequencer.
    always_comb begin
        state_d    = state_q;
        rw_d       = rw_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        fault_d    = fault_q;
        gap_d      = 1'b0;
        raw_lo_d   = raw_lo_q;
        raw_hi_d   = raw_hi_q;
        resp_valid = 1'b0;
        resp_rdata = 32'd0;
        resp_fault = 1'b0;
        mem_enable = 1'b0;
        mem_rw     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = 32'd0;
        mem_be     = 4'd0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    rw_d     = req_rw;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    raw_lo_d = 32'd0;
                    raw_hi_d = 32'd0;
                    if (!req_legal || (req_misaligned && !SPLIT_EN)) begin
                        fault_d = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        fault_d = 1'b0;
                        state_d = ST_ACC0;
                    end
                end
            end
            ST_ACC0: begin
                mem_enable = 1'b1;
                mem_rw     = rw_q;
                mem_addr   = word0_addr;
                mem_be     = be_wide[3:0];
                mem_wdata  = wdata_wide[31:0];
                if (mem_valid) begin
                    raw_lo_d = mem_rdata & lane_mask(be_wide[3:0]);
                    if (|be_wide[7:4]) begin
                        gap_d   = 1'b1;
                        state_d = ST_ACC1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_ACC1: begin
                mem_enable = ~gap_q;
                mem_rw     = rw_q;
                mem_addr   = word1_addr;
                mem_be     = be_wide[7:4];
                mem_wdata  = wdata_wide[63:32];
                if (mem_valid && !gap_q) begin
                    raw_hi_d = mem_rdata & lane_mask(be_wide[7:4]);
                    state_d  = ST_DONE;
                end
            end
            default: begin
                resp_valid = 1'b1;
                resp_fault = fault_q;
                resp_rdata = (rw_q || fault_q) ? 32'd0 : rd_ext;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // State and request registers; asynchronous reset abandons any access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rw_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            fault_q  <= 1'b0;
            gap_q    <= 1'b0;
            raw_lo_q <= 32'd0;
            raw_hi_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            rw_q     <= rw_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            fault_q  <= fault_d;
            gap_q    <= gap_d;
            raw_lo_q <= raw_lo_d;
            raw_hi_q <= raw_hi_d;
        end
    end

endmodule
`default_nettype wire
